// File: rtl/dma_multi_channel.sv
// Multi-channel DMA controller: per-channel src/dst/len registers,
// round-robin arbitration and a hold/acknowledge bus handshake.
module dma_multi_channel #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 8,
  parameter int BURST  = 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              hld,
  input  logic              hlda,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  output logic [CH_W-1:0]   active_ch
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_READ, S_WRITE, S_RELEASE, S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q [NUM_CH];
  logic [ADDR_W-1:0] src_d [NUM_CH];
  logic [ADDR_W-1:0] dst_q [NUM_CH];
  logic [ADDR_W-1:0] dst_d [NUM_CH];
  logic [LEN_W-1:0]  len_q [NUM_CH];
  logic [LEN_W-1:0]  len_d [NUM_CH];
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   act_q, act_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] busy_w;
  logic [CH_W-1:0]   pick;
  logic              found;
  logic [LEN_W-1:0]  len_nxt;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy_w[i] = |len_q[i];
    end
  end

  assign busy      = busy_w;
  assign done      = done_q;
  assign active_ch = act_q;

  // Search starts one past the last served channel.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_q) + i) % NUM_CH;
      if (!found && busy_w[CH_W'(idx)]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    rr_d      = rr_q;
    data_d    = data_q;
    done_d    = '0;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    len_nxt   = len_q[act_q] - LEN_W'(1);
    hld       = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (cfg_we && !busy_w[cfg_ch]) begin
      if (cfg_len == '0) begin
        done_d[cfg_ch] = 1'b1;
      end else begin
        src_d[cfg_ch] = cfg_src;
        dst_d[cfg_ch] = cfg_dst;
        len_d[cfg_ch] = cfg_len;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          act_d   = pick;
          rr_d    = CH_W'((int'(pick) + 1) % NUM_CH);
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        hld = 1'b1;
        if (hlda) state_d = S_READ;
      end
      S_READ: begin
        hld      = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = src_q[act_q];
        data_d   = mem_rdata;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        hld           = 1'b1;
        mem_wr        = 1'b1;
        mem_addr      = dst_q[act_q];
        mem_wdata     = data_q;
        src_d[act_q]  = src_q[act_q] + ADDR_W'(1);
        dst_d[act_q]  = dst_q[act_q] + ADDR_W'(1);
        len_d[act_q]  = len_nxt;
        // done is registered so it is visible during FINISH
        if (len_nxt == '0) begin
          state_d       = S_FINISH;
          done_d[act_q] = 1'b1;
        end else if (BURST != 0 && hlda) begin
          state_d = S_READ;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      act_q   <= '0;
      rr_q    <= '0;
      done_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        len_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      act_q   <= act_d;
      rr_q    <= rr_d;
      done_q  <= done_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_dma_multi_channel.sv
// Directed bench for dma_multi_channel: burst and cycle-steal instances
// sharing clock and reset, memory returns addr ^ 16'h5A5A.
module tb_dma_multi_channel;

  logic        clk = 1'b0;
  logic        rst;

  logic        cfg_we0, cfg_we1;
  logic [0:0]  cfg_ch0, cfg_ch1;
  logic [15:0] cfg_src0, cfg_src1, cfg_dst0, cfg_dst1;
  logic [7:0]  cfg_len0, cfg_len1;
  logic        hld0, hld1, hlda0, hlda1;
  logic [15:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
  logic        rd0, rd1, wr0, wr1;
  logic [1:0]  busy0, busy1, done0, done1;
  logic [0:0]  act0, act1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata0 = rd0 ? (addr0 ^ 16'h5A5A) : 16'h0;
  assign rdata1 = rd1 ? (addr1 ^ 16'h5A5A) : 16'h0;

  dma_multi_channel #(.BURST(1)) u_burst (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we0), .cfg_ch(cfg_ch0), .cfg_src(cfg_src0),
    .cfg_dst(cfg_dst0), .cfg_len(cfg_len0),
    .hld(hld0), .hlda(hlda0),
    .mem_addr(addr0), .mem_rd(rd0), .mem_wr(wr0),
    .mem_wdata(wdata0), .mem_rdata(rdata0),
    .busy(busy0), .done(done0), .active_ch(act0)
  );

  dma_multi_channel #(.BURST(0)) u_steal (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we1), .cfg_ch(cfg_ch1), .cfg_src(cfg_src1),
    .cfg_dst(cfg_dst1), .cfg_len(cfg_len1),
    .hld(hld1), .hlda(hlda1),
    .mem_addr(addr1), .mem_rd(rd1), .mem_wr(wr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1),
    .busy(busy1), .done(done1), .active_ch(act1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog0(input logic ch, input logic [15:0] s,
                       input logic [15:0] d, input logic [7:0] n);
    cfg_we0  = 1'b1;
    cfg_ch0  = ch;
    cfg_src0 = s;
    cfg_dst0 = d;
    cfg_len0 = n;
    tick();
    cfg_we0  = 1'b0;
  endtask

  task automatic prog1(input logic ch, input logic [15:0] s,
                       input logic [15:0] d, input logic [7:0] n);
    cfg_we1  = 1'b1;
    cfg_ch1  = ch;
    cfg_src1 = s;
    cfg_dst1 = d;
    cfg_len1 = n;
    tick();
    cfg_we1  = 1'b0;
  endtask

  initial begin
    logic [15:0] raddr [4];
    int          ract  [4];
    bit          rgap  [4];
    int          n, ndone;
    bit          low_seen;

    rst = 1'b1;
    cfg_we0 = 0; cfg_ch0 = 0; cfg_src0 = 0; cfg_dst0 = 0; cfg_len0 = 0;
    cfg_we1 = 0; cfg_ch1 = 0; cfg_src1 = 0; cfg_dst1 = 0; cfg_len1 = 0;
    hlda0 = 1'b1;
    hlda1 = 1'b1;
    #3;
    check("rst_hld", hld0, 0);
    check("rst_strobes", {rd0, wr0}, 0);
    check("rst_addr", addr0, 0);
    check("rst_busy_done", {busy0, done0}, 0);
    check("rst_act", act0, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // burst copy of three words
    prog0(0, 16'h0010, 16'h0100, 8'd3);
    check("b_busy", busy0, 2'b01);
    check("b_hld_early", hld0, 0);
    tick();
    check("b_hld_rise", hld0, 1);
    check("b_req_strobes", {rd0, wr0}, 0);
    for (int w = 0; w < 3; w++) begin
      tick();
      check("b_rd", {hld0, rd0, wr0}, 3'b110);
      check("b_rd_addr", addr0, 16'h0010 + w);
      tick();
      check("b_wr", {hld0, rd0, wr0}, 3'b101);
      check("b_wr_addr", addr0, 16'h0100 + w);
      check("b_wdata", wdata0, (16'h0010 + w) ^ 16'h5A5A);
    end
    tick();
    check("b_fin_hld", hld0, 0);
    check("b_done", done0, 2'b01);
    check("b_busy_clr", busy0, 0);
    tick();
    check("b_done_once", done0, 0);

    // handshake stall on channel 1
    hlda0 = 1'b0;
    prog0(1, 16'h0020, 16'h0200, 8'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("s_hld", hld0, 1);
      check("s_no_strobe", {rd0, wr0}, 0);
      tick();
    end
    check("s_still_req", {hld0, rd0, wr0}, 3'b100);
    hlda0 = 1'b1;
    tick();
    check("s_rd", rd0, 1);
    check("s_rd_addr", addr0, 16'h0020);
    check("s_act", act0, 1);
    tick();
    check("s_wr_addr", addr0, 16'h0200);
    tick();
    check("s_done", done0, 2'b10);

    // zero length
    prog0(0, 16'h0000, 16'h0000, 8'd0);
    check("z_done", done0, 2'b01);
    check("z_busy", busy0, 0);
    check("z_hld", hld0, 0);
    tick();
    check("z_done_clr", done0, 0);
    check("z_hld2", hld0, 0);
    tick();
    check("z_hld3", hld0, 0);

    // source address wrap
    prog0(0, 16'hFFFF, 16'h0300, 8'd2);
    tick();
    tick();
    check("w_rd0", addr0, 16'hFFFF);
    tick();
    tick();
    check("w_rd1", {rd0, addr0}, {1'b1, 16'h0000});
    tick();
    check("w_wr1", {wr0, addr0}, {1'b1, 16'h0301});
    tick();
    check("w_done", done0, 2'b01);

    // reprogramming a busy channel is ignored
    hlda0 = 1'b0;
    prog0(0, 16'h0040, 16'h0400, 8'd1);
    prog0(0, 16'h0050, 16'h0500, 8'd5);
    check("r_busy", busy0, 2'b01);
    hlda0 = 1'b1;
    tick();
    check("r_rd_addr", addr0, 16'h0040);
    tick();
    check("r_wr_addr", addr0, 16'h0400);
    tick();
    check("r_done", {done0, busy0}, {2'b01, 2'b00});

    // reset during the write of word 2 of 4
    prog0(0, 16'h0060, 16'h0600, 8'd4);
    tick();
    tick();
    tick();
    tick();
    tick();
    check("x_wr2", {wr0, addr0}, {1'b1, 16'h0601});
    #1 rst = 1'b1;
    #1;
    check("x_async_hld", hld0, 0);
    check("x_async_str", {rd0, wr0}, 0);
    check("x_async_bus", {addr0, wdata0}, 0);
    check("x_async_st", {busy0, done0, act0}, 0);
    tick();
    check("x_no_done", done0, 0);
    rst = 1'b0;
    tick();
    check("x_idle", {busy0, done0, hld0}, 0);
    prog0(0, 16'h0070, 16'h0700, 8'd1);
    tick();
    check("x_req", hld0, 1);
    tick();
    check("x_rd_addr", {rd0, addr0}, {1'b1, 16'h0070});
    tick();
    check("x_wr", {wr0, addr0, wdata0},
          {1'b1, 16'h0700, 16'h0070 ^ 16'h5A5A});
    tick();
    check("x_done", done0, 2'b01);

    // cycle-steal interleave
    prog1(0, 16'h0010, 16'h1000, 8'd2);
    prog1(1, 16'h0080, 16'h1800, 8'd2);
    n = 0;
    ndone = 0;
    low_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!hld1) low_seen = 1'b1;
      if (rd1 && n < 4) begin
        raddr[n] = addr1;
        ract[n]  = int'(act1);
        rgap[n]  = low_seen;
        low_seen = 1'b0;
        n++;
      end
      ndone += $countones(done1);
      tick();
    end
    check("i_nreads", n, 4);
    if (n == 4) begin
      check("i_addr0", raddr[0], 16'h0010);
      check("i_addr1", raddr[1], 16'h0080);
      check("i_addr2", raddr[2], 16'h0011);
      check("i_addr3", raddr[3], 16'h0081);
      check("i_order", {ract[0][0], ract[1][0], ract[2][0], ract[3][0]},
            4'b0101);
      check("i_gap", {rgap[1], rgap[2], rgap[3]}, 3'b111);
    end
    check("i_ndone", ndone, 2);
    check("i_busy", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
